// File: rtl/mem_arbiter.sv
// Two-port (IF / LS) arbiter and sequencer in front of the single-ported mem_unit.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LS has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_valid_i,
    output logic                  if_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_rsp_valid_o,
    input  logic                  ls_req_valid_i,
    output logic                  ls_req_ready_o,
    input  logic                  ls_wr_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  mem_en_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   gnt_ls_q;
    logic   sel_ls;
    logic   grant;

`ifdef MEM_ARB_RR_EN
    logic last_ls_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = grant ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = grant ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On a tie, round-robin hands the grant to whichever port lost last time.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        sel_ls = ls_req_valid_i && (!if_req_valid_i || !last_ls_q);
`else
        sel_ls = ls_req_valid_i;
`endif
        ls_req_ready_o = (state_q != ACCESS) && sel_ls;
        if_req_ready_o = (state_q != ACCESS) && if_req_valid_i && !sel_ls;
        grant          = ls_req_ready_o || if_req_ready_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_en_o       <= 1'b0;
            mem_wr_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            rsp_data_o     <= '0;
            if_rsp_valid_o <= 1'b0;
            ls_rsp_valid_o <= 1'b0;
            gnt_ls_q       <= 1'b0;
        end else begin
            mem_en_o       <= 1'b0;
            mem_wr_o       <= 1'b0;
            if_rsp_valid_o <= 1'b0;
            ls_rsp_valid_o <= 1'b0;
            if (state_q == ACCESS) begin
                if (!(gnt_ls_q && mem_wr_o)) begin
                    rsp_data_o <= mem_data_i;
                end
                if_rsp_valid_o <= !gnt_ls_q;
                ls_rsp_valid_o <= gnt_ls_q;
            end
            if (grant) begin
                mem_en_o   <= 1'b1;
                mem_wr_o   <= ls_req_ready_o && ls_wr_i;
                mem_addr_o <= ls_req_ready_o ? ls_addr_i : if_addr_i;
                mem_data_o <= ls_req_ready_o ? ls_wdata_i : '0;
                gnt_ls_q   <= ls_req_ready_o;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_ls_q <= 1'b1;
        end else if (grant) begin
            last_ls_q <= ls_req_ready_o;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model
// and a behavioural mem_unit stand-in.
module tb_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_v = 1'b0;
    logic          if_rdy;
    logic [AW-1:0] if_addr = '0;
    logic          if_rsp;
    logic          ls_v = 1'b0;
    logic          ls_rdy;
    logic          ls_wr = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_rsp;
    logic [DW-1:0] rsp_data;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd = '0;

    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic          acc = 0, acc_ls = 0, acc_wr = 0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0, acc_rdata = '0;
    logic          rsp = 0, rsp_ls = 0;
    logic [DW-1:0] exp_data = '0;
    logic          last_ls = 1'b1;
    logic          prev_en = 0;
    logic          hs_if = 0, hs_ls = 0;
    int            g_if = 0, g_ls = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_req_valid_i (if_v),
        .if_req_ready_o (if_rdy),
        .if_addr_i      (if_addr),
        .if_rsp_valid_o (if_rsp),
        .ls_req_valid_i (ls_v),
        .ls_req_ready_o (ls_rdy),
        .ls_wr_i        (ls_wr),
        .ls_addr_i      (ls_addr),
        .ls_wdata_i     (ls_wdata),
        .ls_rsp_valid_o (ls_rsp),
        .rsp_data_o     (rsp_data),
        .mem_en_o       (mem_en),
        .mem_wr_o       (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_data_i     (mem_rd)
    );

    always #5 clk = ~clk;

    // mem_unit stand-in: samples on the falling edge while enabled
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem_arr[mem_addr] = mem_wdata;
            else        mem_rd = mem_arr[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        acc = 0; acc_ls = 0; acc_wr = 0;
        rsp = 0; rsp_ls = 0;
        exp_data = '0; last_ls = 1'b1; prev_en = 0;
        hs_if = 0; hs_ls = 0;
    endtask

    // One clock: check at negedge, advance model, return at posedge+1.
    task automatic step();
        logic pick_ls, e_if, e_ls;
        @(negedge clk);
        pick_ls = ls_v;
        if (ls_v && if_v) begin
`ifdef MEM_ARB_RR_EN
            pick_ls = !last_ls;
`else
            pick_ls = 1'b1;
`endif
        end
        e_ls = !acc && ls_v && pick_ls;
        e_if = !acc && if_v && !pick_ls;
        check("ls_ready", ls_rdy, e_ls);
        check("if_ready", if_rdy, e_if);
        check("mem_en", mem_en, acc);
        check("mem_en_gap", prev_en & mem_en, 0);
        prev_en = mem_en;
        if (acc) begin
            check("mem_wr", mem_wr, acc_wr);
            check("mem_addr", mem_addr, acc_addr);
            check("mem_data", mem_wdata, acc_wdata);
        end else begin
            check("mem_wr_idle", mem_wr, 0);
        end
        check("if_rsp", if_rsp, rsp && !rsp_ls);
        check("ls_rsp", ls_rsp, rsp && rsp_ls);
        check("rsp_data", rsp_data, exp_data);

        rsp = acc;
        rsp_ls = acc_ls;
        if (acc && !(acc_ls && acc_wr)) exp_data = acc_rdata;
        hs_if = e_if;
        hs_ls = e_ls;
        acc = e_if || e_ls;
        if (e_ls) begin
            acc_ls = 1; acc_wr = ls_wr; acc_addr = ls_addr;
            acc_wdata = ls_wdata; acc_rdata = ref_mem[ls_addr];
            if (ls_wr) ref_mem[ls_addr] = ls_wdata;
            last_ls = 1; g_ls++;
        end else if (e_if) begin
            acc_ls = 0; acc_wr = 0; acc_addr = if_addr;
            acc_wdata = '0; acc_rdata = ref_mem[if_addr];
            last_ls = 0; g_if++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; if_v = 0; ls_v = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_wdata, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_if_rsp", if_rsp, 0);
        check("rst_ls_rsp", ls_rsp, 0);
        rst = 0;
        model_reset();
    endtask

    task automatic req_ls(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        bit done = 0;
        ls_v = 1; ls_wr = wr; ls_addr = a; ls_wdata = d;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            done = hs_ls;
        end
        check("ls_accept", done, 1);
        ls_v = 0;
    endtask

    task automatic req_if(input logic [AW-1:0] a);
        bit done = 0;
        if_v = 1; if_addr = a;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            done = hs_if;
        end
        check("if_accept", done, 1);
        if_v = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;

        @(posedge clk);
        #1;
        do_reset();

        // IF read of word 5
        req_if(11'h005);
        step();
        check("if5_valid", if_rsp, 1);
        check("if5_ls_quiet", ls_rsp, 0);
        check("if5_data", rsp_data, 32'hDEADBEEF);

        // LS write then read back
        req_ls(1'b1, 11'h010, 32'h12345678);
        step();
        check("wr_ack", ls_rsp, 1);
        req_ls(1'b0, 11'h010, 32'h0);
        step();
        check("rd_back", rsp_data, 32'h12345678);

        // both ports requesting for 6 cycles
        do_reset();
        g_if = 0; g_ls = 0;
        if_v = 1; if_addr = 11'h003;
        ls_v = 1; ls_wr = 0; ls_addr = 11'h004;
        repeat (6) step();
        if_v = 0; ls_v = 0;
`ifdef MEM_ARB_RR_EN
        check("tie_if_grants", g_if, 2);
        check("tie_ls_grants", g_ls, 1);
`else
        check("tie_if_grants", g_if, 0);
        check("tie_ls_grants", g_ls, 3);
`endif
        repeat (2) step();

        // back-to-back LS reads
        ls_v = 1; ls_wr = 0; ls_addr = 11'h001;
        step();
        check("b2b_first", hs_ls, 1);
        ls_addr = 11'h002;
        step();
        step();
        check("b2b_second", hs_ls, 1);
        ls_v = 0;
        repeat (2) step();

        // reset during ACCESS
        req_ls(1'b0, 11'h007, 32'h0);
        check("abort_en_before", mem_en, 1);
        rst = 1;
        #1;
        check("abort_en_async", mem_en, 0);
        @(negedge clk);
        check("abort_no_ls_rsp", ls_rsp, 0);
        check("abort_no_if_rsp", if_rsp, 0);
        @(posedge clk);
        #1;
        check("abort_no_rsp_late", ls_rsp, 0);
        rst = 0;
        model_reset();
        req_ls(1'b0, 11'h007, 32'h0);
        step();
        check("after_rst_rsp", ls_rsp, 1);

        // idle
        repeat (10) step();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            if (!if_v || hs_if) begin
                if_v = 1'($urandom_range(0, 1));
                if_addr = AW'($urandom_range(0, 15));
            end
            if (!ls_v || hs_ls) begin
                ls_v = 1'($urandom_range(0, 1));
                ls_wr = 1'($urandom_range(0, 1));
                ls_addr = AW'($urandom_range(0, 15));
                ls_wdata = $urandom;
            end
            step();
        end
        if_v = 0; ls_v = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported mem_unit.
- Shares the memory between the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write).
- Drives the memory's enable, write, address and data pins, and captures the read data one cycle after the access.
- Returns the response to whichever port was granted.

Parameters:
ADDR_WIDTH, 11, memory word-address width (matches mem_unit).
DATA_WIDTH, 32, data word width.

Ports:
clk_i  in  1  clock; the single clock, shared with mem_unit
rst_i  in  1  reset; asynchronous, active-high
if_req_valid_i  in  1  IF read request
if_req_ready_o  out  1  IF request accepted this cycle (combinational)
if_addr_i  in  ADDR_WIDTH  IF read address
if_rsp_valid_o  out  1  one-cycle pulse: IF read data valid on rsp_data_o
ls_req_valid_i  in  1  LS request
ls_req_ready_o  out  1  LS request accepted this cycle (combinational)
ls_wr_i  in  1  1 = write, 0 = read
ls_addr_i  in  ADDR_WIDTH  LS address
ls_wdata_i  in  DATA_WIDTH  LS write data
ls_rsp_valid_o  out  1  one-cycle pulse: LS read data valid, or write acknowledged
rsp_data_o  out  DATA_WIDTH  captured read data (shared by both ports)
mem_en_o  out  1  to mem_unit en_i
mem_wr_o  out  1  to mem_unit wr_i
mem_addr_o  out  ADDR_WIDTH  to mem_unit addr_i
mem_data_o  out  DATA_WIDTH  to mem_unit data_i
mem_data_i  in  DATA_WIDTH  from mem_unit data_o

Behaviour:
- Reset (async, rst_i=1):
  - State = IDLE.
  - mem_en_o, mem_wr_o, both rsp_valid outputs = 0.
  - mem_addr_o, mem_data_o, rsp_data_o = 0.
  - Round-robin pointer = LS (see Optional Feature).
  - Reset mid-access drops mem_en_o immediately; no response is issued for the aborted access.
- FSM states: IDLE, ACCESS, RESP.
- Grant: only in IDLE or RESP, when at least one req_valid is high.
  - Without the optional feature: LS has fixed priority over IF.
  - Exactly one req_ready_o is high, combinationally, for the selected port. Both are 0 in ACCESS.
  - The handshake completes at the posedge where valid and ready are both 1.
- Grant edge k:
  - Register mem_en_o=1, mem_wr_o (LS: ls_wr_i; IF: 0), mem_addr_o and mem_data_o (LS: ls_wdata_i; IF: 0).
  - Latch the granted port id.
  - Go to ACCESS.
- ACCESS (cycle k):
  - mem_unit samples on the negedge inside cycle k, so read data is stable before posedge k+1.
  - At posedge k+1: capture mem_data_i into rsp_data_o, unless the access is an LS write, in which case rsp_data_o holds its previous value.
  - At the same edge: clear mem_en_o and mem_wr_o, pulse the granted port's rsp_valid for cycle k+1, and go to RESP.
- RESP (cycle k+1):
  - rsp_valid is deasserted at posedge k+2.
  - At posedge k+2, grant a new request if any is pending (back-to-back), else go to IDLE.
- Latency and throughput:
  - Latency from request acceptance to response is 1 cycle.
  - Peak throughput is one access per 2 cycles.
- Requesters must accept the response in its pulse cycle; there is no response back-pressure.
- Requests not granted wait; valid must be held with address and data stable until ready.
- mem_en_o is never high for two consecutive cycles. Between accesses mem_unit is disabled and its output is high-Z.
- Addresses pass through unmodified; no range checking.

Optional Feature:
MEM_ARB_RR_EN
- Defined:
  - When both ports are valid, grant the port not granted last.
  - The pointer updates on every grant and resets to LS, so the first tie goes to IF.
  - A single valid port is always granted.
- Undefined: fixed LS-over-IF priority; the pointer logic is absent. IF can starve under continuous LS traffic.

Test Plan:
- Reset then IF read of addr 0x005 (mem[5]=0xDEADBEEF): ready at edge k; if_rsp_valid_o=1 for one cycle at k+1 with rsp_data_o=0xDEADBEEF; ls_rsp_valid_o stays 0.
- LS write 0x12345678 to 0x010, then LS read of 0x010: write ack pulse on ls_rsp_valid_o; the read returns 0x12345678; mem_wr_o high only during the write ACCESS cycle.
- IF and LS both valid for 6 cycles, macro undefined: three LS grants and zero IF grants. Macro defined: grants alternate IF, LS, IF.
- Continuous LS reads to 0x001/0x002: grants at edges k and k+2; mem_en_o pattern 1,0,1,0; responses at k+1 and k+3.
- Assert rst_i during ACCESS: mem_en_o falls without waiting for a clock; no rsp_valid pulse; the next request after reset is served normally.
- Idle with no requests: mem_en_o=0 and both ready outputs = 0 for 10 cycles.
